// File: rtl/uart_cmd_decoder.sv
// Merges debounced buttons with single-character UART commands for control_unit,
// applies UART mode toggles to the slide switches, and echoes accepted bytes.
module uart_cmd_decoder #(
  parameter int ECHO_EN = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_done,
  input  logic       i_btn_up,
  input  logic       i_btn_down,
  input  logic       i_btn_left,
  input  logic       i_btn_right,
  input  logic       i_sw_watch_select,
  input  logic       i_sw_edit,
  input  logic       i_tx_busy,
  output logic       o_up,
  output logic       o_down,
  output logic       o_left,
  output logic       o_right,
  output logic       o_watch_select,
  output logic       o_edit,
  output logic       o_tx_start,
  output logic [7:0] o_tx_data,
  output logic       o_cmd_err,
  output logic       o_echo_drop
);
  localparam logic ECHO = (ECHO_EN != 0);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t     state;
  logic [1:0] to_cnt;
  logic       pend_valid;
  logic [7:0] pend_data;
  logic       mode_tgl, edit_tgl;

  // Setting bit 5 folds upper case onto lower case; only the two case variants alias.
  logic [7:0] rx_lc;
  logic       is_u, is_d, is_l, is_r, is_m, is_e, is_cmd;
  logic       cmd_bad, buf_free, load, drop;
  logic       mode_nxt, edit_nxt;
  logic [7:0] echo_byte;

  assign rx_lc     = i_rx_data | 8'h20;
  assign is_u      = i_rx_done && (rx_lc == 8'h75);
  assign is_d      = i_rx_done && (rx_lc == 8'h64);
  assign is_l      = i_rx_done && (rx_lc == 8'h6C);
  assign is_r      = i_rx_done && (rx_lc == 8'h72);
  assign is_m      = i_rx_done && (rx_lc == 8'h6D);
  assign is_e      = i_rx_done && (rx_lc == 8'h65);
  assign is_cmd    = is_u | is_d | is_l | is_r | is_m | is_e;
  assign cmd_bad   = i_rx_done && !is_cmd;
  assign echo_byte = is_cmd ? i_rx_data : 8'h3F;

  // The buffer counts as free in START because its entry is handed off that cycle.
  assign buf_free  = !pend_valid || (state == START);
  assign load      = ECHO && i_rx_done && buf_free;
  assign drop      = ECHO && i_rx_done && !buf_free;

  assign mode_nxt  = mode_tgl ^ is_m;
  assign edit_nxt  = edit_tgl ^ is_e;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_up           <= 1'b0;
      o_down         <= 1'b0;
      o_left         <= 1'b0;
      o_right        <= 1'b0;
      o_watch_select <= 1'b0;
      o_edit         <= 1'b0;
      o_tx_start     <= 1'b0;
      o_tx_data      <= 8'h00;
      o_cmd_err      <= 1'b0;
      o_echo_drop    <= 1'b0;
      mode_tgl       <= 1'b0;
      edit_tgl       <= 1'b0;
      pend_valid     <= 1'b0;
      pend_data      <= 8'h00;
      to_cnt         <= 2'd0;
      state          <= IDLE;
    end else begin
      o_up           <= i_btn_up    | is_u;
      o_down         <= i_btn_down  | is_d;
      o_left         <= i_btn_left  | is_l;
      o_right        <= i_btn_right | is_r;
      mode_tgl       <= mode_nxt;
      edit_tgl       <= edit_nxt;
      o_watch_select <= i_sw_watch_select ^ mode_nxt;
      o_edit         <= i_sw_edit ^ edit_nxt;
      o_cmd_err      <= cmd_bad;
      o_echo_drop    <= drop;
      o_tx_start     <= 1'b0;

      if (load) begin
        pend_valid <= 1'b1;
        pend_data  <= echo_byte;
      end else if (state == START) begin
        pend_valid <= 1'b0;
      end

      case (state)
        IDLE: if (ECHO && pend_valid && !i_tx_busy) begin
          state      <= START;
          o_tx_start <= 1'b1;
          o_tx_data  <= pend_data;
        end
        START: begin
          state  <= WAIT_BUSY;
          to_cnt <= 2'd0;
        end
        WAIT_BUSY: begin
          // Give up after four cycles if the transmitter never acknowledges.
          if (i_tx_busy)            state <= WAIT_DONE;
          else if (to_cnt == 2'd3)  state <= IDLE;
          else                      to_cnt <= to_cnt + 2'd1;
        end
        WAIT_DONE: if (!i_tx_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Cycle-level bench: directed scenarios then random traffic, each cycle compared
// against an event-level model of decode, echo buffer and transmitter occupancy.
module tb_uart_cmd_decoder;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] i_rx_data;
  logic       i_rx_done;
  logic       i_btn_up, i_btn_down, i_btn_left, i_btn_right;
  logic       i_sw_watch_select, i_sw_edit, i_tx_busy;
  logic       o_up, o_down, o_left, o_right, o_watch_select, o_edit;
  logic       o_tx_start, o_cmd_err, o_echo_drop;
  logic [7:0] o_tx_data;

  always #5 clk = ~clk;

  uart_cmd_decoder #(.ECHO_EN(1)) dut (
    .clk(clk), .reset(reset), .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
    .i_btn_up(i_btn_up), .i_btn_down(i_btn_down), .i_btn_left(i_btn_left),
    .i_btn_right(i_btn_right), .i_sw_watch_select(i_sw_watch_select),
    .i_sw_edit(i_sw_edit), .i_tx_busy(i_tx_busy), .o_up(o_up), .o_down(o_down),
    .o_left(o_left), .o_right(o_right), .o_watch_select(o_watch_select),
    .o_edit(o_edit), .o_tx_start(o_tx_start), .o_tx_data(o_tx_data),
    .o_cmd_err(o_cmd_err), .o_echo_drop(o_echo_drop)
  );

  int checks = 0;
  int failures = 0;

  // Model state: values visible on the outputs in the current cycle.
  logic       m_up, m_dn, m_lf, m_rt, m_ws, m_ed, m_st, m_err, m_drop;
  logic [7:0] m_txd, m_pd;
  logic       m_pv, m_mt, m_et;
  int         free_at, last_s, last_b;

  logic [16:0] dv;
  assign dv = {o_up, o_down, o_left, o_right, o_watch_select, o_edit,
               o_tx_start, o_cmd_err, o_echo_drop, o_tx_data};

  function automatic logic [16:0] mvec();
    return {m_up, m_dn, m_lf, m_rt, m_ws, m_ed, m_st, m_err, m_drop, m_txd};
  endfunction

  // 1..6 = up, down, left, right, mode, edit; 0 = unrecognised.
  function automatic int cmd_of(logic [7:0] b);
    case (b)
      8'h55, 8'h75: return 1;
      8'h44, 8'h64: return 2;
      8'h4C, 8'h6C: return 3;
      8'h52, 8'h72: return 4;
      8'h4D, 8'h6D: return 5;
      8'h45, 8'h65: return 6;
      default:      return 0;
    endcase
  endfunction

  // Busy duration the bench's transmitter shows after a start at cycle s.
  function automatic int busy_len(int s);
    if (s < 60) return 3;
    if (s >= 270 && s < 278) return 0;
    if (s < 400) return 100;
    return int'($urandom_range(0, 6));
  endfunction

  task automatic chk(string name, int k, logic [16:0] act, logic [16:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", name, k, act, req);
    end
  endtask

  task automatic lit(string name, int k, logic [16:0] dut_v, logic [16:0] mod_v,
                     logic [16:0] want);
    chk({name, "_dut"}, k, dut_v, want);
    chk({name, "_model"}, k, mod_v, want);
  endtask

  logic [7:0] cmds [12];

  initial begin
    logic       rx, bu, bd, bl, br, sw_ws, sw_ed, rst, busy_k, nst, ld;
    logic [7:0] rxd;
    int         c;

    cmds = '{8'h55, 8'h75, 8'h44, 8'h64, 8'h4C, 8'h6C,
             8'h52, 8'h72, 8'h4D, 8'h6D, 8'h45, 8'h65};
    {m_up, m_dn, m_lf, m_rt, m_ws, m_ed, m_st, m_err, m_drop} = '0;
    m_txd = 8'h00; m_pd = 8'h00; m_pv = 1'b0; m_mt = 1'b0; m_et = 1'b0;
    free_at = 0; last_s = -1000; last_b = 0;
    sw_ws = 1'b0; sw_ed = 1'b0;

    reset = 1'b1; i_rx_data = 8'h00; i_rx_done = 1'b0;
    i_btn_up = 1'b0; i_btn_down = 1'b0; i_btn_left = 1'b0; i_btn_right = 1'b0;
    i_sw_watch_select = 1'b0; i_sw_edit = 1'b0; i_tx_busy = 1'b0;

    for (int k = 0; k < 3400; k++) begin
      @(negedge clk);
      chk("outputs", k, dv, mvec());

      case (k)
        11:  lit("u_up", k, o_up, m_up, 1);
        12:  begin
               lit("u_up_end", k, o_up, m_up, 0);
               lit("u_echo", k, {o_tx_start, o_tx_data}, {m_st, m_txd}, {1'b1, 8'h75});
             end
        21:  lit("merge_left", k, o_left, m_lf, 1);
        22:  begin
               lit("merge_left_end", k, o_left, m_lf, 0);
               lit("l_echo", k, {o_tx_start, o_tx_data}, {m_st, m_txd}, {1'b1, 8'h4C});
             end
        23:  lit("up_down", k, {o_up, o_down, o_echo_drop}, {m_up, m_dn, m_drop}, 3'b110);
        28:  lit("d_echo", k, {o_tx_start, o_tx_data}, {m_st, m_txd}, {1'b1, 8'h64});
        31:  lit("mode_tgl", k, o_watch_select, m_ws, 1);
        36:  lit("mode_sw", k, o_watch_select, m_ws, 0);
        41:  lit("edit_tgl1", k, o_edit, m_ed, 1);
        43:  lit("edit_tgl2", k, o_edit, m_ed, 0);
        51:  lit("err", k, {o_cmd_err, o_up, o_down, o_left, o_right},
                 {m_err, m_up, m_dn, m_lf, m_rt}, 5'b10000);
        54:  lit("err_echo", k, {o_tx_start, o_tx_data}, {m_st, m_txd}, {1'b1, 8'h3F});
        61:  lit("ovf_up", k, o_up, m_up, 1);
        63:  lit("ovf_down", k, o_down, m_dn, 1);
        65:  lit("ovf_drop", k, {o_right, o_echo_drop}, {m_rt, m_drop}, 2'b11);
        165: lit("ovf_d_echo", k, {o_tx_start, o_tx_data}, {m_st, m_txd}, {1'b1, 8'h64});
        277: lit("timeout_wait", k, o_tx_start, m_st, 0);
        278: lit("timeout_echo", k, {o_tx_start, o_tx_data}, {m_st, m_txd}, {1'b1, 8'h72});
        291: lit("reset_all", k, dv, mvec(), 17'h0);
        293: lit("reset_sw", k, o_watch_select, m_ws, 1);
        default: ;
      endcase

      // Stimulus for this cycle.
      rx = 1'b0; rxd = 8'h00; bu = 1'b0; bd = 1'b0; bl = 1'b0; br = 1'b0;
      if (k < 400) begin
        rst   = (k < 2) || (k == 290) || (k == 291);
        sw_ws = (k >= 35);
        sw_ed = 1'b0;
        case (k)
          10:  begin rx = 1'b1; rxd = 8'h75; end
          20:  begin rx = 1'b1; rxd = 8'h4C; bl = 1'b1; end
          22:  begin rx = 1'b1; rxd = 8'h64; bu = 1'b1; end
          30:  begin rx = 1'b1; rxd = 8'h6D; end
          40, 42: begin rx = 1'b1; rxd = 8'h45; end
          50:  begin rx = 1'b1; rxd = 8'h41; end
          60:  begin rx = 1'b1; rxd = 8'h75; end
          62:  begin rx = 1'b1; rxd = 8'h64; end
          64:  begin rx = 1'b1; rxd = 8'h72; end
          270: begin rx = 1'b1; rxd = 8'h6C; end
          274: begin rx = 1'b1; rxd = 8'h72; end
          default: ;
        endcase
      end else begin
        rst = ($urandom_range(0, 599) == 0);
        rx  = ($urandom_range(0, 2) == 0);
        rxd = ($urandom_range(0, 3) == 0) ? 8'($urandom) : cmds[$urandom_range(0, 11)];
        bu  = ($urandom_range(0, 7) == 0);
        bd  = ($urandom_range(0, 7) == 0);
        bl  = ($urandom_range(0, 7) == 0);
        br  = ($urandom_range(0, 7) == 0);
        if ($urandom_range(0, 19) == 0) sw_ws = ~sw_ws;
        if ($urandom_range(0, 19) == 0) sw_ed = ~sw_ed;
      end
      busy_k = (k > last_s) && (k <= last_s + last_b);

      reset = rst; i_rx_done = rx; i_rx_data = rxd;
      i_btn_up = bu; i_btn_down = bd; i_btn_left = bl; i_btn_right = br;
      i_sw_watch_select = sw_ws; i_sw_edit = sw_ed; i_tx_busy = busy_k;

      // Model: outputs visible in the next cycle.
      if (rst) begin
        {m_up, m_dn, m_lf, m_rt, m_ws, m_ed, m_st, m_err, m_drop} = '0;
        m_txd = 8'h00; m_pv = 1'b0; m_mt = 1'b0; m_et = 1'b0; free_at = 0;
      end else begin
        c    = rx ? cmd_of(rxd) : -1;
        nst  = m_pv && (k >= free_at) && !busy_k;
        m_up = bu | (c == 1);
        m_dn = bd | (c == 2);
        m_lf = bl | (c == 3);
        m_rt = br | (c == 4);
        m_mt = m_mt ^ (c == 5);
        m_et = m_et ^ (c == 6);
        m_ws = sw_ws ^ m_mt;
        m_ed = sw_ed ^ m_et;
        m_err  = (c == 0);
        ld     = rx && (!m_pv || m_st);
        m_drop = rx && !ld;
        if (nst) m_txd = m_pd;
        if (ld) begin
          m_pv = 1'b1;
          m_pd = (c == 0) ? 8'h3F : rxd;
        end else if (m_st) begin
          m_pv = 1'b0;
        end
        m_st = nst;
        if (nst) begin
          last_s  = k + 1;
          last_b  = busy_len(k + 1);
          free_at = k + 1 + ((last_b > 0) ? last_b + 2 : 5);
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
